ysyx_22040127_ifu: RTL and testbench

YSYX_22040127_IFU -- requirements
Module: ysyx_22040127_ifu

---
 rtl/ysyx_22040127_pkg.sv | 26 ++
 rtl/ysyx_22040127_ifu_if.sv | 27 ++
 rtl/ysyx_22040127_ifu_fifo.sv | 70 +++++++
 rtl/ysyx_22040127_ifu.sv | 110 +++++++++++
 tb/tb_ysyx_22040127_ifu.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040127_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// The lane and offset helpers are derived from the memory bus width.
package ysyx_22040127_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StDrop
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } inst_entry_t;

  function automatic int unsigned lane_count(int unsigned bus_w);
    return bus_w / 32;
  endfunction

  function automatic int unsigned off_width(int unsigned bus_w);
    return $clog2(bus_w / 8);
  endfunction

endpackage

// File: rtl/ysyx_22040127_ifu_if.sv
// Fetch unit channels: memory request/response, redirect from execute and decode handoff.
// The master modport is the fetch unit's view of these channels.
interface ysyx_22040127_ifu_if #(
  parameter int unsigned BUS_W = 64
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_addr;
  logic             rsp_valid;
  logic [BUS_W-1:0] rsp_data;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst;
  logic [31:0]      inst_pc;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc,
    input  req_ready, rsp_valid, rsp_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc,
    output req_ready, rsp_valid, rsp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ysyx_22040127_ifu_fifo.sv
// Instruction buffer: up to PUSH_N pushes and one pop per cycle, flush wins over both.
// Circular storage; free_cnt lets the producer avoid overflow.
module ysyx_22040127_ifu_fifo
  import ysyx_22040127_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PUSH_N = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [$clog2(PUSH_N+1)-1:0]      push_cnt,
  input  inst_entry_t                      push_data [PUSH_N],
  input  logic                             pop,
  output inst_entry_t                      head,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       free_cnt
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  inst_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_add(logic [PTR_W-1:0] p, int unsigned n);
    return PTR_W'((32'(p) + n) % DEPTH);
  endfunction

  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  assign head     = mem_q[rd_ptr_q];
  assign free_cnt = CNT_W'(DEPTH) - count_q;

  always_comb begin
    wr_ptr_d = ptr_add(wr_ptr_q, 32'(push_cnt));
    rd_ptr_d = do_pop ? ptr_add(rd_ptr_q, 1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_cnt) - CNT_W'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int unsigned j = 0; j < PUSH_N; j++) begin
        if (j < 32'(push_cnt)) begin
          mem_q[ptr_add(wr_ptr_q, j)] <= push_data[j];
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_22040127_ifu.sv
// Instruction fetch unit: one outstanding bus request, wide responses split into 32-bit
// lanes and buffered for decode; redirects flush the buffer and drop stale responses.
module ysyx_22040127_ifu
  import ysyx_22040127_pkg::*;
#(
  parameter int unsigned BUS_W    = 64,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_22040127_ifu_if.master  bus
);
  localparam int unsigned L          = lane_count(BUS_W);
  localparam int unsigned OFF_W      = off_width(BUS_W);
  localparam logic [31:0] OFF_MASK   = 32'((1 << OFF_W) - 1);
  localparam logic [31:0] LINE_BYTES = 32'(BUS_W / 8);
  localparam int unsigned PCW        = $clog2(L + 1);
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1);

  ifu_state_e       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             en_q;
  logic [31:0]      aligned_pc;
  logic [31:0]      lane_start;
  logic             req_fire;
  logic             push;
  logic [PCW-1:0]   push_cnt;
  inst_entry_t      push_data [L];
  inst_entry_t      head;
  logic             empty;
  logic [CNT_W-1:0] free_cnt;

  assign aligned_pc    = fetch_pc_q & ~OFF_MASK;
  assign lane_start    = (fetch_pc_q & OFF_MASK) >> 2;
  assign bus.req_addr  = aligned_pc;
  // en_q holds off the first request until one edge after reset release
  assign bus.req_valid = en_q && (state_q == StFetch) && (free_cnt >= CNT_W'(L));
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign push          = (state_q == StWait) && bus.rsp_valid && !bus.redirect_valid;

  // Lanes lane_start..L-1 are packed into push slots 0.. in ascending order
  always_comb begin
    push_cnt = push ? PCW'(L - lane_start) : '0;
    for (int unsigned j = 0; j < L; j++) begin
      push_data[j] = '0;
      if (j + lane_start < L) begin
        push_data[j].inst = bus.rsp_data[32*(j+lane_start) +: 32];
        push_data[j].pc   = aligned_pc + 32'(4 * (j + lane_start));
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      StFetch: if (req_fire) state_d = StWait;
      StWait: begin
        if (bus.rsp_valid) begin
          state_d    = StFetch;
          fetch_pc_d = aligned_pc + LINE_BYTES;
        end
      end
      StDrop:  if (bus.rsp_valid) state_d = StFetch;
      default: state_d = StFetch;
    endcase
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~32'h3;
      // Go to DROP whenever a request is still in flight after this edge
      unique case (state_q)
        StFetch:        state_d = req_fire ? StDrop : StFetch;
        StWait, StDrop: state_d = bus.rsp_valid ? StFetch : StDrop;
        default:        state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_PC;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      en_q       <= 1'b1;
    end
  end

  ysyx_22040127_ifu_fifo #(
    .DEPTH  (DEPTH),
    .PUSH_N (L)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop       (bus.inst_ready),
    .head      (head),
    .empty     (empty),
    .free_cnt  (free_cnt)
  );

  assign bus.inst_valid = !empty;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_ysyx_22040127_ifu.sv
// Directed bench for the fetch unit (64-bit bus) plus a randomized PC-sequence run on a
// 32-bit-bus instance against a simple reference PC model.
module tb_ysyx_22040127_ifu;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_22040127_ifu_if #(.BUS_W(64)) bus64 ();
  ysyx_22040127_ifu_if #(.BUS_W(32)) bus32 ();

  ysyx_22040127_ifu #(
    .BUS_W    (64),
    .DEPTH    (4),
    .RESET_PC (32'h8000_0000)
  ) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  ysyx_22040127_ifu #(
    .BUS_W    (32),
    .DEPTH    (4),
    .RESET_PC (32'h8000_0000)
  ) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (bus64.req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_req_valid: got %b want 0", bus64.req_valid);
    end
    checks++;
    if (bus64.inst_valid !== 1'b0) begin
      errors++; $display("FAIL reset_inst_valid: got %b want 0", bus64.inst_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus64.req_valid !== 1'b0) begin
      errors++; $display("FAIL release_no_edge_req_valid: got %b want 0", bus64.req_valid);
    end
    step();
    checks++;
    if (bus64.req_valid !== 1'b1 || bus64.req_addr !== 32'h8000_0000) begin
      errors++; $display("FAIL first_req: got v=%b a=%h want v=1 a=80000000",
                         bus64.req_valid, bus64.req_addr);
    end
  endtask

  task automatic test_basic();
    bus64.req_ready = 1'b1;
    step();
    bus64.req_ready = 1'b0;
    checks++;
    if (bus64.req_valid !== 1'b0) begin
      errors++; $display("FAIL wait_req_valid: got %b want 0", bus64.req_valid);
    end
    bus64.rsp_valid = 1'b1;
    bus64.rsp_data  = 64'h00100093_00000013;
    step();
    bus64.rsp_valid = 1'b0;
    checks++;
    if (bus64.inst_valid !== 1'b1 || bus64.inst !== 32'h0000_0013 ||
        bus64.inst_pc !== 32'h8000_0000) begin
      errors++; $display("FAIL basic_lane0: got v=%b i=%h pc=%h want v=1 i=00000013 pc=80000000",
                         bus64.inst_valid, bus64.inst, bus64.inst_pc);
    end
    checks++;
    if (bus64.req_valid !== 1'b1 || bus64.req_addr !== 32'h8000_0008) begin
      errors++; $display("FAIL basic_next_req: got v=%b a=%h want v=1 a=80000008",
                         bus64.req_valid, bus64.req_addr);
    end
    bus64.inst_ready = 1'b1;
    step();
    checks++;
    if (bus64.inst_valid !== 1'b1 || bus64.inst !== 32'h0010_0093 ||
        bus64.inst_pc !== 32'h8000_0004) begin
      errors++; $display("FAIL basic_lane1: got v=%b i=%h pc=%h want v=1 i=00100093 pc=80000004",
                         bus64.inst_valid, bus64.inst, bus64.inst_pc);
    end
    step();
    bus64.inst_ready = 1'b0;
    checks++;
    if (bus64.inst_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drained: got %b want 0", bus64.inst_valid);
    end
  endtask

  task automatic test_redirect_lane();
    bus64.redirect_valid = 1'b1;
    bus64.redirect_pc    = 32'h8000_0015;
    step();
    bus64.redirect_valid = 1'b0;
    checks++;
    if (bus64.req_valid !== 1'b1 || bus64.req_addr !== 32'h8000_0010) begin
      errors++; $display("FAIL redir_req: got v=%b a=%h want v=1 a=80000010",
                         bus64.req_valid, bus64.req_addr);
    end
    bus64.req_ready = 1'b1;
    step();
    bus64.req_ready = 1'b0;
    bus64.rsp_valid = 1'b1;
    bus64.rsp_data  = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    bus64.rsp_valid = 1'b0;
    checks++;
    if (bus64.inst_valid !== 1'b1 || bus64.inst !== 32'hAAAA_BBBB ||
        bus64.inst_pc !== 32'h8000_0014) begin
      errors++; $display("FAIL redir_upper_lane: got v=%b i=%h pc=%h want v=1 i=aaaabbbb pc=80000014",
                         bus64.inst_valid, bus64.inst, bus64.inst_pc);
    end
    checks++;
    if (bus64.req_addr !== 32'h8000_0018) begin
      errors++; $display("FAIL redir_next_addr: got %h want 80000018", bus64.req_addr);
    end
    bus64.inst_ready = 1'b1;
    step();
    bus64.inst_ready = 1'b0;
    checks++;
    if (bus64.inst_valid !== 1'b0) begin
      errors++; $display("FAIL redir_single_lane: got inst_valid %b want 0", bus64.inst_valid);
    end
  endtask

  task automatic test_redirect_wait();
    bus64.req_ready = 1'b1;
    step();
    bus64.req_ready      = 1'b0;
    bus64.redirect_valid = 1'b1;
    bus64.redirect_pc    = 32'h8000_0040;
    step();
    bus64.redirect_valid = 1'b0;
    checks++;
    if (bus64.req_valid !== 1'b0) begin
      errors++; $display("FAIL drop_req_valid: got %b want 0", bus64.req_valid);
    end
    step();
    step();
    bus64.rsp_valid = 1'b1;
    bus64.rsp_data  = 64'h1234_5678_9ABC_DEF0;
    step();
    bus64.rsp_valid = 1'b0;
    checks++;
    if (bus64.inst_valid !== 1'b0 || bus64.req_valid !== 1'b1 ||
        bus64.req_addr !== 32'h8000_0040) begin
      errors++; $display("FAIL drop_after_rsp: got iv=%b rv=%b a=%h want iv=0 rv=1 a=80000040",
                         bus64.inst_valid, bus64.req_valid, bus64.req_addr);
    end
    // redirect together with the response in WAIT
    bus64.req_ready = 1'b1;
    step();
    bus64.req_ready      = 1'b0;
    bus64.rsp_valid      = 1'b1;
    bus64.redirect_valid = 1'b1;
    bus64.redirect_pc    = 32'h8000_0100;
    step();
    bus64.rsp_valid      = 1'b0;
    bus64.redirect_valid = 1'b0;
    checks++;
    if (bus64.inst_valid !== 1'b0 || bus64.req_valid !== 1'b1 ||
        bus64.req_addr !== 32'h8000_0100) begin
      errors++; $display("FAIL redir_with_rsp: got iv=%b rv=%b a=%h want iv=0 rv=1 a=80000100",
                         bus64.inst_valid, bus64.req_valid, bus64.req_addr);
    end
    // redirect together with a request handshake
    bus64.req_ready      = 1'b1;
    bus64.redirect_valid = 1'b1;
    bus64.redirect_pc    = 32'h8000_0202;
    step();
    bus64.req_ready      = 1'b0;
    bus64.redirect_valid = 1'b0;
    checks++;
    if (bus64.req_valid !== 1'b0 || bus64.req_addr !== 32'h8000_0200) begin
      errors++; $display("FAIL redir_with_req: got v=%b a=%h want v=0 a=80000200",
                         bus64.req_valid, bus64.req_addr);
    end
    bus64.rsp_valid = 1'b1;
    step();
    bus64.rsp_valid = 1'b0;
    checks++;
    if (bus64.inst_valid !== 1'b0 || bus64.req_valid !== 1'b1) begin
      errors++; $display("FAIL redir_with_req_drop: got iv=%b rv=%b want iv=0 rv=1",
                         bus64.inst_valid, bus64.req_valid);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 2; i++) begin
      bus64.req_ready = 1'b1;
      step();
      bus64.req_ready = 1'b0;
      bus64.rsp_valid = 1'b1;
      bus64.rsp_data  = {32'hB0 + 32'(2 * i + 1), 32'hB0 + 32'(2 * i)};
      step();
      bus64.rsp_valid = 1'b0;
    end
    checks++;
    if (bus64.req_valid !== 1'b0 || bus64.inst_pc !== 32'h8000_0200) begin
      errors++; $display("FAIL full_stall: got v=%b pc=%h want v=0 pc=80000200",
                         bus64.req_valid, bus64.inst_pc);
    end
    step();
    checks++;
    if (bus64.req_valid !== 1'b0) begin
      errors++; $display("FAIL full_stall_hold: got %b want 0", bus64.req_valid);
    end
    bus64.inst_ready = 1'b1;
    step();
    bus64.inst_ready = 1'b0;
    checks++;
    if (bus64.req_valid !== 1'b0 || bus64.inst !== 32'h0000_00B1 ||
        bus64.inst_pc !== 32'h8000_0204) begin
      errors++; $display("FAIL one_pop: got v=%b i=%h pc=%h want v=0 i=000000b1 pc=80000204",
                         bus64.req_valid, bus64.inst, bus64.inst_pc);
    end
    bus64.inst_ready = 1'b1;
    step();
    bus64.inst_ready = 1'b0;
    checks++;
    if (bus64.req_valid !== 1'b1 || bus64.req_addr !== 32'h8000_0210 ||
        bus64.inst_pc !== 32'h8000_0208) begin
      errors++; $display("FAIL two_pops: got v=%b a=%h pc=%h want v=1 a=80000210 pc=80000208",
                         bus64.req_valid, bus64.req_addr, bus64.inst_pc);
    end
  endtask

  task automatic test_reset_mid();
    bus64.req_ready = 1'b1;
    step();
    bus64.req_ready = 1'b0;
    checks++;
    if (bus64.inst_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_inst_valid: got %b want 1", bus64.inst_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus64.req_valid !== 1'b0 || bus64.inst_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got rv=%b iv=%b want rv=0 iv=0",
                         bus64.req_valid, bus64.inst_valid);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if (bus64.req_valid !== 1'b1 || bus64.req_addr !== 32'h8000_0000) begin
      errors++; $display("FAIL post_reset_req: got v=%b a=%h want v=1 a=80000000",
                         bus64.req_valid, bus64.req_addr);
    end
  endtask

  task automatic test_wrap();
    bus64.redirect_valid = 1'b1;
    bus64.redirect_pc    = 32'hFFFF_FFFB;
    step();
    bus64.redirect_valid = 1'b0;
    checks++;
    if (bus64.req_addr !== 32'hFFFF_FFF8) begin
      errors++; $display("FAIL wrap_req_addr: got %h want fffffff8", bus64.req_addr);
    end
    bus64.req_ready = 1'b1;
    step();
    bus64.req_ready = 1'b0;
    bus64.rsp_valid = 1'b1;
    bus64.rsp_data  = 64'h1111_1111_2222_2222;
    step();
    bus64.rsp_valid = 1'b0;
    checks++;
    if (bus64.inst !== 32'h2222_2222 || bus64.inst_pc !== 32'hFFFF_FFF8 ||
        bus64.req_addr !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_lane0: got i=%h pc=%h a=%h want i=22222222 pc=fffffff8 a=00000000",
                         bus64.inst, bus64.inst_pc, bus64.req_addr);
    end
    bus64.inst_ready = 1'b1;
    step();
    checks++;
    if (bus64.inst !== 32'h1111_1111 || bus64.inst_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_lane1: got i=%h pc=%h want i=11111111 pc=fffffffc",
                         bus64.inst, bus64.inst_pc);
    end
    step();
    bus64.inst_ready = 1'b0;
  endtask

  task automatic test_random32();
    logic [31:0] exp_pc = 32'h8000_0000;
    logic [31:0] paddr  = '0;
    bit          pending = 1'b0;
    int          cnt    = 0;
    int          pops   = 0;
    for (int it = 0; it < 3000; it++) begin
      bus32.rsp_valid = 1'b0;
      if (pending) begin
        if (cnt == 0) begin
          bus32.rsp_valid = 1'b1;
          bus32.rsp_data  = mem_word(paddr);
          pending         = 1'b0;
        end else begin
          cnt--;
        end
      end
      bus32.req_ready      = ($urandom_range(0, 2) != 0);
      bus32.inst_ready     = ($urandom_range(0, 3) != 0);
      bus32.redirect_valid = ($urandom_range(0, 24) == 0);
      bus32.redirect_pc    = 32'h8000_0000 | ($urandom & 32'h0000_03FF);
      if (bus32.req_valid && bus32.req_ready) begin
        pending = 1'b1;
        paddr   = bus32.req_addr;
        cnt     = $urandom_range(0, 3);
      end
      if (bus32.inst_valid && bus32.inst_ready && !bus32.redirect_valid) begin
        checks++;
        if (bus32.inst_pc !== exp_pc || bus32.inst !== mem_word(exp_pc)) begin
          errors++; $display("FAIL rand_seq it=%0d: got pc=%h i=%h want pc=%h i=%h",
                             it, bus32.inst_pc, bus32.inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        pops++;
      end
      if (bus32.redirect_valid) exp_pc = bus32.redirect_pc & ~32'h3;
      step();
    end
    bus32.rsp_valid      = 1'b0;
    bus32.redirect_valid = 1'b0;
    checks++;
    if (pops < 200) begin
      errors++; $display("FAIL rand_progress: got %0d pops want at least 200", pops);
    end
  endtask

  initial begin
    rst                  = 1'b0;
    bus64.req_ready      = 1'b0;
    bus64.rsp_valid      = 1'b0;
    bus64.rsp_data       = '0;
    bus64.redirect_valid = 1'b0;
    bus64.redirect_pc    = '0;
    bus64.inst_ready     = 1'b0;
    bus32.req_ready      = 1'b0;
    bus32.rsp_valid      = 1'b0;
    bus32.rsp_data       = '0;
    bus32.redirect_valid = 1'b0;
    bus32.redirect_pc    = '0;
    bus32.inst_ready     = 1'b0;
    test_reset();
    test_basic();
    test_redirect_lane();
    test_redirect_wait();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
